// File: rtl/key_scan_pkg.sv
// Shared constants for the key scan sequencer: FSM encoding, line count and
// debounce counter width.
package key_scan_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;

  localparam int NUM_LINES = 5;
  localparam int DB_CNT_W  = 4;

endpackage

// File: rtl/key_debounce_cell.sv
// Per-line debouncer: flips its state after DebounceCount consecutive disagreeing
// samples; latency one cycle from sample strobe; no backpressure.
module key_debounce_cell
  import key_scan_pkg::*;
#(
  parameter int DebounceCount = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_i,
  input  logic detect_i,
  output logic state_o,
  output logic press_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LIMIT = DB_CNT_W'(DebounceCount);

  logic [DB_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                state_q, state_d;
  logic                press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    press_d = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    if (sample_i) begin
      if (detect_i == state_q) begin
        cnt_d = '0;
      end else if (cnt_inc >= CNT_LIMIT) begin
        // Flip and restart; the counter never rests above the limit.
        state_d = detect_i;
        cnt_d   = '0;
        press_d = detect_i;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
    end
  end

  assign state_o = state_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_scan_sequencer.sv
// One-hot drive sweep over 5 lines with a single NOR sense return; each line is
// held DwellCycles then sampled, and results are debounced per line.
module key_scan_sequencer
  import key_scan_pkg::*;
#(
  parameter int         DwellCycles     = 4,
  parameter int         DebounceCount   = 3,
  parameter logic [4:0] DriveInvertMask = 5'b00000,
  parameter bit         SenseActiveLow  = 1'b1
) (
  input  logic       GlobalClock,
  input  logic       Reset,
  input  logic       ScanEnable,
  input  logic       Sense_Line,
  output logic       Drive_1,
  output logic       Drive_2,
  output logic       Drive_3,
  output logic       Drive_4,
  output logic       Drive_5,
  output logic [4:0] Key_State,
  output logic [4:0] Key_Press,
  output logic       Scan_Done
);

  localparam logic [7:0] DWELL_RELOAD = 8'(DwellCycles - 1);
  localparam logic       SENSE_IDLE   = SenseActiveLow;

  logic [1:0] sync_q;
  logic       detect;
  logic [1:0] state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [7:0] dwell_q, dwell_d;
  logic       done_q, done_d;
  logic [NUM_LINES-1:0] raw_drive;
  logic [NUM_LINES-1:0] drive;

  assign detect = SenseActiveLow ? ~sync_q[1] : sync_q[1];

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ScanEnable) begin
          state_d = SETTLE;
          ch_d    = 3'd0;
          dwell_d = DWELL_RELOAD;
        end
      end
      SETTLE: begin
        if (dwell_q == 8'd0) state_d = SAMPLE;
        else                 dwell_d = dwell_q - 8'd1;
      end
      SAMPLE: begin
        done_d  = (ch_q == 3'd4);
        ch_d    = (ch_q == 3'd4) ? 3'd0 : ch_q + 3'd1;
        dwell_d = DWELL_RELOAD;
        state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase
    // Disable wins over every transition, but a SAMPLE in flight still reports.
    if (!ScanEnable) begin
      state_d = IDLE;
      ch_d    = 3'd0;
      dwell_d = 8'd0;
    end
  end

  always_ff @(posedge GlobalClock or posedge Reset) begin
    if (Reset) begin
      sync_q  <= {2{SENSE_IDLE}};
      state_q <= IDLE;
      ch_q    <= 3'd0;
      dwell_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], Sense_Line};
      state_q <= state_d;
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    assign raw_drive[i] = (state_q != IDLE) && (ch_q == 3'(i));

    key_debounce_cell #(
      .DebounceCount(DebounceCount)
    ) u_cell (
      .clk_i   (GlobalClock),
      .rst_i   (Reset),
      .sample_i((state_q == SAMPLE) && (ch_q == 3'(i))),
      .detect_i(detect),
      .state_o (Key_State[i]),
      .press_o (Key_Press[i])
    );
  end

  assign drive     = raw_drive ^ DriveInvertMask;
  assign Drive_1   = drive[0];
  assign Drive_2   = drive[1];
  assign Drive_3   = drive[2];
  assign Drive_4   = drive[3];
  assign Drive_5   = drive[4];
  assign Scan_Done = done_q;

endmodule

// File: tb/tb_key_scan_sequencer.sv
// Randomised bench for key_scan_sequencer against a sweep-position model, with
// literal checks of the directed scenarios.
module tb_key_scan_sequencer;

  localparam int D     = 4;
  localparam int DB    = 3;
  localparam int PER   = D + 1;
  localparam int SWEEP = 5 * PER;
  localparam logic [4:0] MASK_B = 5'b10101;

  logic       clk = 1'b0;
  logic       rst, en, sense;
  logic [4:0] keys;
  logic [4:0] drv_a, drv_b, ks_a, kp_a, ks_b, kp_b;
  logic       sd_a, sd_b;

  int  n_chk = 0;
  int  n_pass = 0;
  bit  chk_on = 1'b0;

  // Model: sweep position counted from the first enabled cycle.
  bit         m_idle;
  int         m_pos;
  logic [4:0] m_ks, m_kp;
  logic       m_sd;
  int         m_cnt [5];
  logic       s1, s2;

  key_scan_sequencer #(.DwellCycles(D), .DebounceCount(DB), .DriveInvertMask(5'b00000),
                       .SenseActiveLow(1'b1)) u_dut_a (
    .GlobalClock(clk), .Reset(rst), .ScanEnable(en), .Sense_Line(sense),
    .Drive_1(drv_a[0]), .Drive_2(drv_a[1]), .Drive_3(drv_a[2]), .Drive_4(drv_a[3]),
    .Drive_5(drv_a[4]), .Key_State(ks_a), .Key_Press(kp_a), .Scan_Done(sd_a));

  key_scan_sequencer #(.DwellCycles(D), .DebounceCount(DB), .DriveInvertMask(MASK_B),
                       .SenseActiveLow(1'b1)) u_dut_b (
    .GlobalClock(clk), .Reset(rst), .ScanEnable(en), .Sense_Line(sense),
    .Drive_1(drv_b[0]), .Drive_2(drv_b[1]), .Drive_3(drv_b[2]), .Drive_4(drv_b[3]),
    .Drive_5(drv_b[4]), .Key_State(ks_b), .Key_Press(kp_b), .Scan_Done(sd_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int active_line();
    return m_idle ? -1 : m_pos / PER;
  endfunction

  function automatic logic [4:0] raw_drv();
    logic [4:0] r;
    int l;
    r = 5'b0;
    l = active_line();
    if (l >= 0) r[l] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    m_pos  = 0;
    m_ks   = 5'b0;
    m_kp   = 5'b0;
    m_sd   = 1'b0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    s1 = 1'b1;
    s2 = 1'b1;
  endtask

  task automatic model_step();
    int   l;
    logic det;
    if (rst) begin
      model_reset();
      return;
    end
    m_kp = 5'b0;
    m_sd = 1'b0;
    if (!m_idle && (m_pos % PER) == PER - 1) begin
      l   = m_pos / PER;
      det = ~s2;
      if (det == m_ks[l]) m_cnt[l] = 0;
      else begin
        m_cnt[l]++;
        if (m_cnt[l] >= DB) begin
          m_ks[l]  = det;
          m_cnt[l] = 0;
          m_kp[l]  = det;
        end
      end
      m_sd = (l == 4);
    end
    if (!en) begin
      m_idle = 1'b1;
      m_pos  = 0;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_pos  = 0;
    end else begin
      m_pos = (m_pos + 1) % SWEEP;
    end
    s2 = s1;
    s1 = sense;
  endtask

  // Apply inputs for one cycle (NOR matrix: sense low while a pressed line is driven).
  task automatic cyc(input logic r, input logic e, input logic [4:0] k);
    int l;
    rst  = r;
    en   = e;
    keys = k;
    if (r) model_reset();
    l = active_line();
    sense = !(l >= 0 && keys[l]);
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("drive_a", drv_a, raw_drv());
      chk("drive_b", drv_b, raw_drv() ^ MASK_B);
      chk("key_state", ks_a, m_ks);
      chk("key_press", kp_a, m_kp);
      chk("scan_done", sd_a, m_sd);
      chk("key_state_b", ks_b, m_ks);
      chk("key_press_b", kp_b, m_kp);
      chk("scan_done_b", sd_b, m_sd);
    end
  end

  initial begin
    int done_idx [$];
    int press_n;
    logic [4:0] first_press;
    bit found;
    int hold, off;
    logic [4:0] rk;
    logic re, rr;

    model_reset();
    rst = 1'b1; en = 1'b1; keys = 5'b0; sense = 1'b1;
    cyc(1, 1, 0);
    chk_on = 1'b1;
    cyc(1, 1, 0);
    chk("rst_key_state", ks_a, 5'b00000);
    chk("rst_drive_a", drv_a, 5'b00000);
    chk("rst_drive_b", drv_b, 5'b10101);
    chk("rst_scan_done", sd_a, 1'b0);

    // Idle sweeps, no keys.
    for (int n = 1; n <= 60; n++) begin
      cyc(0, 1, 0);
      if (n == 1) begin
        chk("first_drive_a", drv_a, 5'b00001);
        chk("first_drive_b", drv_b, 5'b10100);
      end
      if (n == 6) chk("second_line", drv_a, 5'b00010);
      if (sd_a) done_idx.push_back(n);
    end
    chk("done_count", done_idx.size(), 2);
    if (done_idx.size() >= 2) begin
      chk("first_done", done_idx[0], 26);
      chk("done_period", done_idx[1] - done_idx[0], 25);
    end
    chk("idle_keys", ks_a, 5'b00000);

    // Mid-sweep reset.
    cyc(1, 1, 0);
    chk("midrst_drive", drv_a, 5'b00000);

    // Line 3 held, then released.
    press_n = 0; first_press = 5'b0;
    for (int n = 0; n < 80; n++) begin
      cyc(0, 1, 5'b00100);
      if (kp_a != 5'b0) begin
        if (press_n == 0) first_press = kp_a;
        press_n++;
      end
    end
    chk("l3_press_val", first_press, 5'b00100);
    chk("l3_press_cnt", press_n, 1);
    chk("l3_state", ks_a, 5'b00100);
    press_n = 0;
    for (int n = 0; n < 80; n++) begin
      cyc(0, 1, 0);
      if (kp_a != 5'b0) press_n++;
    end
    chk("l3_release", ks_a, 5'b00000);
    chk("l3_rel_press", press_n, 0);

    // Two-sweep glitches on line 2 separated by a clean sweep never latch.
    press_n = 0;
    for (int g = 0; g < 2; g++) begin
      for (int n = 0; n < 2 * SWEEP; n++) begin
        cyc(0, 1, 5'b00010);
        if (kp_a != 5'b0) press_n++;
      end
      for (int n = 0; n < SWEEP; n++) begin
        cyc(0, 1, 0);
        if (kp_a != 5'b0) press_n++;
      end
    end
    chk("glitch_state", ks_a, 5'b00000);
    chk("glitch_press", press_n, 0);

    // Line 5 latched, then released with no press pulse.
    for (int n = 0; n < 4 * SWEEP; n++) cyc(0, 1, 5'b10000);
    chk("l5_latched", ks_a, 5'b10000);
    press_n = 0;
    for (int n = 0; n < 4 * SWEEP; n++) begin
      cyc(0, 1, 0);
      if (kp_a != 5'b0) press_n++;
    end
    chk("l5_released", ks_a, 5'b00000);
    chk("l5_rel_press", press_n, 0);

    // Latch line 1, then drop enable mid-SETTLE on line 4.
    for (int n = 0; n < 4 * SWEEP; n++) cyc(0, 1, 5'b00001);
    found = 1'b0;
    for (int n = 0; n < SWEEP + 5 && !found; n++) begin
      if (active_line() == 3 && (m_pos % PER) == 1) found = 1'b1;
      else cyc(0, 1, 5'b00001);
    end
    chk("find_line4", found, 1'b1);
    chk("pre_drop_drive", drv_a, 5'b01000);
    cyc(0, 0, 5'b00001);
    chk("drop_drive_a", drv_a, 5'b00000);
    chk("drop_drive_b", drv_b, 5'b10101);
    chk("drop_keys_held", ks_a, 5'b00001);
    for (int n = 0; n < 9; n++) cyc(0, 0, 5'b00001);
    cyc(0, 1, 5'b00001);
    chk("restart_line1", drv_a, 5'b00001);
    chk("restart_keys", ks_a, 5'b00001);

    // Random keys, enable drops and occasional resets.
    hold = 0; off = 0; rk = 5'b0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        rk   = 5'($urandom);
        hold = $urandom_range(10, 150);
      end else hold--;
      if (off == 0 && $urandom_range(0, 199) == 0) off = $urandom_range(1, 12);
      re = (off == 0);
      if (off > 0) off--;
      rr = ($urandom_range(0, 799) == 0);
      cyc(rr, re, rk);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
